// File: rtl/addsub8_serial.sv
// addsub8_serial: bit-serial add/subtract, one full-adder cell per clock, start/done handshake.
// Define ADDSUB8_SERIAL_ZERO_FLAG_EN to add the registered zero flag output z.
module addsub8_serial #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] e,
    input  logic             m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
`ifdef ADDSUB8_SERIAL_ZERO_FLAG_EN
    ,
    output logic             z
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sa_q, sa_d, se_q, se_d, sum_q, sum_d, s_q, s_d, sum_nx;
    logic             carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
    logic             sum_bit, c_gen;
`ifdef ADDSUB8_SERIAL_ZERO_FLAG_EN
    logic             z_q, z_d;
`endif

    always_comb begin
        sum_bit = sa_q[0] ^ se_q[0] ^ carry_q;
        c_gen   = (sa_q[0] & se_q[0]) | (carry_q & (sa_q[0] ^ se_q[0]));
        sum_nx  = {sum_bit, sum_q[WIDTH-1:1]};
        state_d = state_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        se_d    = se_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        s_d     = s_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
`ifdef ADDSUB8_SERIAL_ZERO_FLAG_EN
        z_d     = z_q;
`endif
        if (state_q == RUN) begin
            sa_d    = sa_q >> 1;
            se_d    = se_q >> 1;
            sum_d   = sum_nx;
            carry_d = c_gen;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                s_d     = sum_nx;
                c_out_d = c_gen;
                ovf_d   = carry_q ^ c_gen;
`ifdef ADDSUB8_SERIAL_ZERO_FLAG_EN
                z_d     = (sum_nx == '0);
`endif
                state_d = DONE;
            end
        end else if (start) begin
            sa_d    = a;
            se_d    = e;
            sum_d   = '0;
            carry_d = m;
            cnt_d   = '0;
            state_d = RUN;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sa_q    <= '0;
            se_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef ADDSUB8_SERIAL_ZERO_FLAG_EN
            z_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            se_q    <= se_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
`ifdef ADDSUB8_SERIAL_ZERO_FLAG_EN
            z_q     <= z_d;
`endif
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign s     = s_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;
`ifdef ADDSUB8_SERIAL_ZERO_FLAG_EN
    assign z     = z_q;
`endif
endmodule

// File: tb/tb_addsub8_serial.sv
// tb_addsub8_serial: directed and random checks of addsub8_serial against an arithmetic model.
module tb_addsub8_serial;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, m = 1'b0;
    logic [7:0] a = '0, e = '0;
    logic       busy, done, c_out, ovf;
    logic [7:0] s;
`ifdef ADDSUB8_SERIAL_ZERO_FLAG_EN
    logic       z;
`endif
    int total = 0, bad = 0;

    addsub8_serial dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .e(e), .m(m),
        .busy(busy), .done(done), .s(s), .c_out(c_out), .ovf(ovf)
`ifdef ADDSUB8_SERIAL_ZERO_FLAG_EN
        , .z(z)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, c_out, s} from plain two's-complement arithmetic.
    function automatic logic [9:0] model(input logic [7:0] ai, input logic [7:0] ei, input logic mi);
        logic [8:0] sum;
        logic       v;
        sum = {1'b0, ai} + {1'b0, ei} + {8'b0, mi};
        v   = (ai[7] == ei[7]) && (sum[7] != ai[7]);
        return {v, sum[8], sum[7:0]};
    endfunction

    task automatic check_result(input string tag, input logic [9:0] exp);
        chk({tag, ".s"}, 32'(s), 32'(exp[7:0]));
        chk({tag, ".c_out"}, 32'(c_out), 32'(exp[8]));
        chk({tag, ".ovf"}, 32'(ovf), 32'(exp[9]));
`ifdef ADDSUB8_SERIAL_ZERO_FLAG_EN
        chk({tag, ".z"}, 32'(z), 32'(exp[7:0] == 8'h00));
`endif
    endtask

    // One full operation; with noise set, start/a/e/m are scrambled while busy.
    task automatic op(input string tag, input logic [7:0] ai, input logic [7:0] ei, input logic mi,
                      input bit noise);
        int         busy_cyc;
        logic [7:0] prev_s;
        bit         held;
        prev_s = s;
        held   = 1'b1;
        @(negedge clk);
        a = ai; e = ei; m = mi; start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        busy_cyc = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (busy) busy_cyc++;
            if (s !== prev_s) held = 1'b0;
            if (noise) begin
                start = 1'($urandom); a = 8'($urandom); e = 8'($urandom); m = 1'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy_cycles"}, 32'(busy_cyc), 32'd8);
        chk({tag, ".no_partial"}, 32'(held), 32'd1);
        check_result(tag, model(ai, ei, mi));
        @(negedge clk);
        chk({tag, ".done_fall"}, 32'(done), 32'd0);
        chk({tag, ".busy_after"}, 32'(busy), 32'd0);
        check_result({tag, ".hold"}, model(ai, ei, mi));
    endtask

    initial begin
        int         dones;
        logic [7:0] ra, rb;
        logic       rm;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset.busy", 32'(busy), 0);
        chk("reset.done", 32'(done), 0);
        check_result("reset", 10'h000);

        op("add", 8'h05, 8'h03, 1'b0, 1'b0);
        op("sub1", 8'h05, 8'hFC, 1'b1, 1'b0);
        op("sub2", 8'h80, 8'hFE, 1'b1, 1'b0);
        op("povf", 8'h7F, 8'h01, 1'b0, 1'b0);
        op("wrap", 8'hFF, 8'h01, 1'b0, 1'b0);
        op("noise", 8'h3C, 8'h5A, 1'b0, 1'b1);
        op("zero", 8'h05, 8'hFA, 1'b1, 1'b0);
        op("nonzero", 8'h05, 8'h03, 1'b0, 1'b0);

        // Back-to-back: start held through DONE launches the second operands.
        @(negedge clk);
        a = 8'h11; e = 8'h22; m = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'hF0; e = 8'hEF; m = 1'b1;
        dones = 0;
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        dones += int'(done);
        check_result("b2b.first", model(8'h11, 8'h22, 1'b0));
        @(negedge clk);
        start = 1'b0;
        chk("b2b.relaunch_busy", 32'(busy), 1);
        chk("b2b.relaunch_done", 32'(done), 0);
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        dones += int'(done);
        check_result("b2b.second", model(8'hF0, 8'hEF, 1'b1));
        repeat (3) begin
            @(negedge clk);
            dones += int'(done);
        end
        chk("b2b.done_pulses", 32'(dones), 2);

        // Reset at cnt=4 aborts the run and clears the outputs.
        @(negedge clk);
        a = 8'h12; e = 8'h34; m = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.busy", 32'(busy), 0);
        chk("midrst.done", 32'(done), 0);
        check_result("midrst", 10'h000);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            dones += int'(done);
        end
        chk("midrst.no_done", 32'(dones), 0);
        op("after_rst", 8'hA5, 8'h5A, 1'b0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            ra = 8'($urandom); rb = 8'($urandom); rm = 1'($urandom);
            op($sformatf("rand%0d", k), ra, rm ? ~rb : rb, rm, k[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
